// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with retired-instruction counter.
// Define MC_HALT_EN to add a HALTED state entered on opcode 14 (left only by rst).
module multi_cycle_controller #(
  parameter int OP_W  = 7,
  parameter int ALU_W = 3,
  parameter int IMM_W = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic [2:0]       f3,
  input  logic             zero,
  input  logic             sign_bit,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             adr_sel,
  output logic             alu_src_b,
  output logic [1:0]       pc_src,
  output logic [1:0]       result_sel,
  output logic [IMM_W-1:0] imm_sel,
  output logic [ALU_W-1:0] alu_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             halted
);
  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB
`ifdef MC_HALT_EN
    , HALTED
`endif
  } stateT;
  stateT state, nextState;
  logic [CNT_W-1:0] count;
  logic isR, isLw, isAddi, isXori, isOri, isSlti, isJalr, isSw, isJal;
  logic isBeq, isBne, isBlt, isBge, isLui, isBranch, isKnown, takeBranch;
  assign isR    = op == OP_W'(0);
  assign isLw   = op == OP_W'(1);
  assign isAddi = op == OP_W'(2);
  assign isXori = op == OP_W'(3);
  assign isOri  = op == OP_W'(4);
  assign isSlti = op == OP_W'(5);
  assign isJalr = op == OP_W'(6);
  assign isSw   = op == OP_W'(7);
  assign isJal  = op == OP_W'(8);
  assign isBeq  = op == OP_W'(9);
  assign isBne  = op == OP_W'(10);
  assign isBlt  = op == OP_W'(11);
  assign isBge  = op == OP_W'(12);
  assign isLui  = op == OP_W'(13);
  assign isBranch = isBeq | isBne | isBlt | isBge;
  assign isKnown = op <= OP_W'(13);
  assign takeBranch = (isBeq & zero) | (isBne & ~zero) | (isBlt & sign_bit) | (isBge & ~sign_bit);
  // Everything is combinational from state, so gating with rst zeroes all outputs in the reset cycle.
  always_comb begin
    nextState = state;
    mem_req = 1'b0;
    mem_we = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    reg_we = 1'b0;
    adr_sel = 1'b0;
    alu_src_b = 1'b0;
    pc_src = 2'b00;
    result_sel = 2'b00;
    imm_sel = '0;
    alu_op = '0;
    instr_done = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          ir_we = mem_ready;
          pc_we = mem_ready;
          nextState = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          imm_sel = isSw ? IMM_W'(1) : isBranch ? IMM_W'(2) : isJal ? IMM_W'(3) : isLui ? IMM_W'(4) : '0;
          instr_done = ~isKnown;
          nextState = isKnown ? EXEC : FETCH;
`ifdef MC_HALT_EN
          if (op == OP_W'(14)) begin
            instr_done = 1'b0;
            nextState = HALTED;
          end
`endif
        end
        EXEC: begin
          alu_op = (isR | isXori | isOri) ? ALU_W'(f3) : (isSlti | isBranch) ? ALU_W'(1) : isLui ? '1 : '0;
          alu_src_b = isAddi | isXori | isOri | isSlti | isLui | isLw | isSw;
          pc_we = takeBranch | isJal | isJalr;
          pc_src = isJalr ? 2'b10 : (isJal | takeBranch) ? 2'b01 : 2'b00;
          reg_we = isJal | isJalr;
          result_sel = (isJal | isJalr) ? 2'b11 : 2'b00;
          instr_done = isBranch | isJal | isJalr;
          nextState = (isLw | isSw) ? MEM : (isBranch | isJal | isJalr) ? FETCH : WB;
        end
        MEM: begin
          mem_req = 1'b1;
          adr_sel = 1'b1;
          mem_we = isSw;
          instr_done = mem_ready & isSw;
          nextState = !mem_ready ? MEM : isLw ? WB : FETCH;
        end
        WB: begin
          reg_we = 1'b1;
          result_sel = isLw ? 2'b01 : isSlti ? 2'b10 : 2'b00;
          instr_done = 1'b1;
          nextState = FETCH;
        end
        default: nextState = state;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      count <= '0;
    end else begin
      state <= nextState;
      if (instr_done) count <= count + 1'b1;
    end
  end
  assign instret = rst ? '0 : count;
`ifdef MC_HALT_EN
  assign halted = !rst && state == HALTED;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: directed checks of the multicycle controller with a 4-bit retired counter.
module tb_multi_cycle_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] f3 = '0;
  logic zero = 1'b0, sign_bit = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, ir_we, pc_we, reg_we, adr_sel, alu_src_b, instr_done, halted;
  logic [1:0] pc_src, result_sel;
  logic [2:0] imm_sel, alu_op;
  logic [3:0] instret;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  multi_cycle_controller #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .zero(zero), .sign_bit(sign_bit),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .reg_we(reg_we), .adr_sel(adr_sel), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .result_sel(result_sel), .imm_sel(imm_sel), .alu_op(alu_op),
    .instr_done(instr_done), .instret(instret), .halted(halted)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // strobes {mem_req,mem_we,ir_we,pc_we,reg_we,adr_sel,alu_src_b,instr_done}; checks then advances one cycle
  task automatic look(input string tag, input logic [7:0] s, input logic [1:0] p, input logic [1:0] r,
                      input logic [2:0] a, input logic [2:0] i);
    #1;
    chk(tag, {mem_req, mem_we, ir_we, pc_we, reg_we, adr_sel, alu_src_b, instr_done,
              pc_src, result_sel, alu_op, imm_sel}, {s, p, r, a, i});
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [6:0] o, input logic [2:0] f, input logic z, input logic sb);
    op = o; f3 = f; zero = z; sign_bit = sb; mem_ready = 1'b1;
    look("fetch", 8'b1011_0000, 2'b00, 2'b00, 3'b000, 3'b000);
  endtask
  initial begin
    look("reset", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    chk("reset_instret", 32'(instret), 0);
    chk("reset_halted", 32'(halted), 0);
    rst = 1'b0;
    op = 7'd2;
    for (int k = 0; k < 3; k++) look("fetch_wait", 8'b1000_0000, 2'b00, 2'b00, 3'b000, 3'b000);
    issue(7'd2, 3'd0, 1'b0, 1'b0);
    look("addi_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    look("addi_exec", 8'b0000_0010, 2'b00, 2'b00, 3'b000, 3'b000);
    look("addi_wb", 8'b0000_1001, 2'b00, 2'b00, 3'b000, 3'b000);
    chk("instret_1", 32'(instret), 1);
    issue(7'd10, 3'd1, 1'b1, 1'b0);
    look("bne_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b010);
    look("bne_nt_exec", 8'b0000_0001, 2'b00, 2'b00, 3'b001, 3'b000);
    chk("instret_2", 32'(instret), 2);
    issue(7'd10, 3'd1, 1'b0, 1'b0);
    look("bne_dec2", 8'h00, 2'b00, 2'b00, 3'b000, 3'b010);
    look("bne_t_exec", 8'b0001_0001, 2'b01, 2'b00, 3'b001, 3'b000);
    chk("instret_3", 32'(instret), 3);
    issue(7'd7, 3'd2, 1'b0, 1'b0);
    look("sw_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b001);
    look("sw_exec", 8'b0000_0010, 2'b00, 2'b00, 3'b000, 3'b000);
    look("sw_mem", 8'b1100_0101, 2'b00, 2'b00, 3'b000, 3'b000);
    chk("instret_4", 32'(instret), 4);
    issue(7'd1, 3'd2, 1'b0, 1'b0);
    look("lw_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    look("lw_exec", 8'b0000_0010, 2'b00, 2'b00, 3'b000, 3'b000);
    mem_ready = 1'b0;
    look("lw_mem_wait", 8'b1000_0100, 2'b00, 2'b00, 3'b000, 3'b000);
    mem_ready = 1'b1;
    look("lw_mem", 8'b1000_0100, 2'b00, 2'b00, 3'b000, 3'b000);
    look("lw_wb", 8'b0000_1001, 2'b00, 2'b01, 3'b000, 3'b000);
    chk("instret_5", 32'(instret), 5);
    issue(7'd5, 3'd2, 1'b0, 1'b0);
    look("slti_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    look("slti_exec", 8'b0000_0010, 2'b00, 2'b00, 3'b001, 3'b000);
    look("slti_wb", 8'b0000_1001, 2'b00, 2'b10, 3'b000, 3'b000);
    issue(7'd3, 3'd4, 1'b0, 1'b0);
    look("xori_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    look("xori_exec", 8'b0000_0010, 2'b00, 2'b00, 3'b100, 3'b000);
    look("xori_wb", 8'b0000_1001, 2'b00, 2'b00, 3'b000, 3'b000);
    issue(7'd0, 3'd6, 1'b0, 1'b0);
    look("r_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    look("r_exec", 8'b0000_0000, 2'b00, 2'b00, 3'b110, 3'b000);
    look("r_wb", 8'b0000_1001, 2'b00, 2'b00, 3'b000, 3'b000);
    issue(7'd13, 3'd0, 1'b0, 1'b0);
    look("lui_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b100);
    look("lui_exec", 8'b0000_0010, 2'b00, 2'b00, 3'b111, 3'b000);
    look("lui_wb", 8'b0000_1001, 2'b00, 2'b00, 3'b000, 3'b000);
    chk("instret_9", 32'(instret), 9);
    issue(7'd8, 3'd0, 1'b0, 1'b0);
    look("jal_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b011);
    look("jal_exec", 8'b0001_1001, 2'b01, 2'b11, 3'b000, 3'b000);
    issue(7'd6, 3'd0, 1'b0, 1'b0);
    look("jalr_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    look("jalr_exec", 8'b0001_1001, 2'b10, 2'b11, 3'b000, 3'b000);
    issue(7'd11, 3'd4, 1'b0, 1'b1);
    look("blt_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b010);
    look("blt_exec", 8'b0001_0001, 2'b01, 2'b00, 3'b001, 3'b000);
    issue(7'd12, 3'd5, 1'b0, 1'b1);
    look("bge_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b010);
    look("bge_exec", 8'b0000_0001, 2'b00, 2'b00, 3'b001, 3'b000);
    issue(7'd15, 3'd0, 1'b0, 1'b0);
    look("unknown_dec", 8'b0000_0001, 2'b00, 2'b00, 3'b000, 3'b000);
    chk("instret_14", 32'(instret), 14);
    issue(7'd2, 3'd0, 1'b0, 1'b0);
    look("addi2_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    look("addi2_exec", 8'b0000_0010, 2'b00, 2'b00, 3'b000, 3'b000);
    look("addi2_wb", 8'b0000_1001, 2'b00, 2'b00, 3'b000, 3'b000);
    chk("instret_15", 32'(instret), 15);
    issue(7'd9, 3'd0, 1'b1, 1'b0);
    look("beq_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b010);
    look("beq_exec", 8'b0001_0001, 2'b01, 2'b00, 3'b001, 3'b000);
    chk("instret_wrap", 32'(instret), 0);
    issue(7'd14, 3'd0, 1'b0, 1'b0);
`ifdef MC_HALT_EN
    look("halt_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    for (int k = 0; k < 20; k++) begin
      chk("halted_hold", 32'(halted), 1);
      look("halted_strobes", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    end
    chk("halt_instret", 32'(instret), 0);
    rst = 1'b1;
    look("halt_reset", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    rst = 1'b0;
    chk("halt_cleared", 32'(halted), 0);
`else
    look("op14_dec", 8'b0000_0001, 2'b00, 2'b00, 3'b000, 3'b000);
    chk("op14_instret", 32'(instret), 1);
    chk("op14_halted", 32'(halted), 0);
`endif
    issue(7'd1, 3'd2, 1'b0, 1'b0);
    look("lw2_dec", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    look("lw2_exec", 8'b0000_0010, 2'b00, 2'b00, 3'b000, 3'b000);
    mem_ready = 1'b0;
    look("lw2_mem_wait", 8'b1000_0100, 2'b00, 2'b00, 3'b000, 3'b000);
    rst = 1'b1;
    #1;
    chk("rst_instret", 32'(instret), 0);
    look("rst_mid_mem", 8'h00, 2'b00, 2'b00, 3'b000, 3'b000);
    rst = 1'b0;
    look("after_rst_fetch", 8'b1000_0000, 2'b00, 2'b00, 3'b000, 3'b000);
    chk("after_rst_instret", 32'(instret), 0);
    chk("after_rst_halted", 32'(halted), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
